// File: rtl/dsp_pkg.sv
// Shared helpers for the DSP pipeline register blocks: depth limit,
// counter-width sizing and a popcount over a stage valid vector.
package dsp_pkg;

  localparam int unsigned MAX_PIPE_DEPTH = 8;

  // Ceiling log2; clog2_f(1) = 0.
  function automatic int unsigned clog2_f(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r++;
    end
    return r;
  endfunction

  // Width of one channel's in-flight counter. A zero-depth bank would need a
  // zero-width field, so it is held at one bit (always 0).
  function automatic int unsigned pipe_cw(input int unsigned depth);
    int unsigned w;
    w = clog2_f(depth + 1);
    return (w == 0) ? 1 : w;
  endfunction

  // Number of set bits in a stage valid vector.
  function automatic logic [3:0] popcount(input logic [MAX_PIPE_DEPTH-1:0] v);
    logic [3:0] n;
    n = '0;
    for (int unsigned i = 0; i < MAX_PIPE_DEPTH; i++) begin
      n = n + 4'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// One channel x one stage of the pipeline register bank: WIDTH data bits plus
// a valid bit. With BYPASS set the stage is a plain wire and holds no state.
module pipe_stage
  import dsp_pkg::*;
#(
  parameter int unsigned      WIDTH   = 18,
  parameter bit               BYPASS  = 1'b0,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             ce,
  input  logic [WIDTH-1:0] d,
  input  logic             in_valid,
  output logic [WIDTH-1:0] q,
  output logic             out_valid
);

  if (BYPASS) begin : g_wire
    logic unused_ok;
    assign unused_ok = &{1'b0, clk, rst, clr, ce};
    assign q         = d;
    assign out_valid = in_valid;
  end else begin : g_reg
    // Stage register: async reset, then sync clear, then enable, else hold.
    // Data loads on ce whether or not the item is valid.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        q         <= RST_VAL;
        out_valid <= 1'b0;
      end else if (clr) begin
        q         <= RST_VAL;
        out_valid <= 1'b0;
      end else if (ce) begin
        q         <= d;
        out_valid <= in_valid;
      end
    end
  end

endmodule

// File: rtl/pipe_reg_bank.sv
// Multi-channel, multi-stage pipeline register bank with per-stage bypass,
// per-channel clock enable, valid tracking and an in-flight item count.
// Channel c uses d/q[c*WIDTH +: WIDTH] and inflight[c*CW +: CW].
module pipe_reg_bank
  import dsp_pkg::*;
#(
  parameter int unsigned                WIDTH       = 18,
  parameter int unsigned                DEPTH       = 2,
  parameter int unsigned                CHANNELS    = 1,
  parameter logic [MAX_PIPE_DEPTH-1:0]  BYPASS_MASK = '0,
  parameter logic [WIDTH-1:0]           RST_VAL     = '0,
  localparam int unsigned               CW          = pipe_cw(DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic [CHANNELS-1:0]        ce,
  input  logic [CHANNELS-1:0]        in_valid,
  input  logic [CHANNELS*WIDTH-1:0]  d,
  output logic [CHANNELS*WIDTH-1:0]  q,
  output logic [CHANNELS-1:0]        out_valid,
  output logic [CHANNELS*CW-1:0]     inflight
);

  // Control inputs are unused when every stage is a wire.
  logic unused_ok;
  assign unused_ok = &{1'b0, clk, rst, clr, ce};

  if (DEPTH > MAX_PIPE_DEPTH) begin : g_bad_depth
    $error("pipe_reg_bank: DEPTH %0d exceeds %0d", DEPTH, MAX_PIPE_DEPTH);
  end

  if ((BYPASS_MASK >> DEPTH) != '0) begin : g_bad_mask
    $error("pipe_reg_bank: BYPASS_MASK has bits above DEPTH %0d", DEPTH);
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [WIDTH-1:0]          ch_d;
    logic [MAX_PIPE_DEPTH-1:0] reg_v;

    assign ch_d = d[c*WIDTH +: WIDTH];

    // Each stage feeds from the previous stage's output; bypassed stages
    // pass straight through and contribute nothing to the in-flight count.
    for (genvar s = 0; s < DEPTH; s++) begin : g_st
      localparam logic [MAX_PIPE_DEPTH-1:0] MASK_SH = BYPASS_MASK >> s;
      logic [WIDTH-1:0] st_d;
      logic [WIDTH-1:0] st_q;
      logic             st_iv;
      logic             st_ov;

      if (s == 0) begin : g_head
        assign st_d  = ch_d;
        assign st_iv = in_valid[c];
      end else begin : g_link
        assign st_d  = g_st[s-1].st_q;
        assign st_iv = g_st[s-1].st_ov;
      end

      pipe_stage #(
        .WIDTH   (WIDTH),
        .BYPASS  (MASK_SH[0]),
        .RST_VAL (RST_VAL)
      ) u_stage (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .ce        (ce[c]),
        .d         (st_d),
        .in_valid  (st_iv),
        .q         (st_q),
        .out_valid (st_ov)
      );

      assign reg_v[s] = MASK_SH[0] ? 1'b0 : st_ov;
    end

    for (genvar s = DEPTH; s < MAX_PIPE_DEPTH; s++) begin : g_pad
      assign reg_v[s] = 1'b0;
    end

    if (DEPTH == 0) begin : g_thru
      assign q[c*WIDTH +: WIDTH] = ch_d;
      assign out_valid[c]        = in_valid[c];
    end else begin : g_tail
      assign q[c*WIDTH +: WIDTH] = g_st[DEPTH-1].st_q;
      assign out_valid[c]        = g_st[DEPTH-1].st_ov;
    end

    assign inflight[c*CW +: CW] = CW'(popcount(reg_v));
  end

endmodule
